ice40_oserdes_gearbox: RTL and testbench
========================================

Name: ice40_oserdes_gearbox

Overview:
Parametrised single-clock transmit gearbox. It accepts DW-bit words over a valid/ready stream and emits them as OW-bit slices, one slice per clock, to feed the IO-cell serializer flops. Between words it inserts no bubbles as long as data keeps arriving. When no data is available it emits a programmable idle word. It also supports word-boundary realignment and sticky underrun detection.

Parameters:
DW, 8, parallel word width; must be a multiple of OW, with DW >= OW.
OW, 2, output slice width per clock (2 = DDR rise/fall pair).
MSB_FIRST, 1, 1: slice 0 is in_data[DW-1 -: OW]; 0: slice 0 is in_data[OW-1:0].
IDLE_WORD, {DW{1'b0}}, word shifted out whenever no data word is available.
Derived: RATIO = DW/OW, the number of slices per word. The slice counter is clog2(RATIO) bits wide, with a minimum of 1 bit.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_data  in  DW  word to serialize.
in_valid  in  1  in_data is valid.
in_ready  out  1  the block accepts the word this cycle.
align  in  1  single-cycle pulse that forces a word boundary.
q  out  OW  current output slice (registered).
q_first  out  1  q is slice 0 of a word (data or idle).
q_idle  out  1  q belongs to an idle word.
underrun  out  1  sticky: a data stream ran dry.
underrun_clr  in  1  clears underrun.

Behaviour:
- State:
  - shift register sr[DW-1:0].
  - slice counter cnt.
  - one-entry holding buffer: buf, buf_full.
  - flags cur_idle and prev_data.
- Reset (asynchronous, takes effect immediately):
  - sr=IDLE_WORD, cnt=0, buf_full=0, cur_idle=1, prev_data=0, underrun=0.
  - Outputs: q=first slice of IDLE_WORD, q_first=1, q_idle=1.
  - in_ready=1 during reset.
- Output: q is always the slice of sr selected by MSB_FIRST. q, q_first and q_idle are all registered.
- Load edge (LE): the clock edge at the end of a cycle in which cnt==RATIO-1, or in which align==1.
  - At an LE: cnt<=0. If buf_full, sr<=buf and cur_idle<=0. Otherwise sr<=IDLE_WORD and cur_idle<=1.
  - At all other edges: cnt<=cnt+1, and sr shifts by OW toward the output end, filling with zeros.
- Buffer handshake:
  - in_ready = !buf_full | LE-cycle. This is combinational from registered state plus align.
  - Accept = in_valid & in_ready.
  - Accept in a non-LE cycle: buf<=in_data, buf_full<=1.
  - Accept in an LE cycle: the old buf moves to sr, the new word goes to buf, and buf_full stays 1.
  - LE cycle with no accept: buf_full<=0.
  - There is no bypass path. Latency is from the accept edge to the first slice on q at the next LE. Minimum is 1 cycle (accept in an LE cycle with the buffer empty goes to buf only, so the word appears after the following LE, at most RATIO+1 cycles).
  - Correction to the above: an accept in an LE cycle with the buffer empty loads buf only; sr loads idle at that edge.
- Throughput: one word per RATIO cycles sustained, with no idle slices between consecutive words as long as in_valid is held.
- Underrun:
  - At each LE, prev_data<=!(loaded word is idle).
  - An LE that loads idle while prev_data==1 sets underrun.
  - underrun_clr clears it. If a set and underrun_clr occur in the same cycle, set wins.
  - The idle stream after reset never flags underrun.
- Align:
  - The current word is truncated. Remaining slices are discarded and never output.
  - align while cnt==RATIO-1 is identical to a normal LE.
  - align held high gives an LE every cycle, so only slice 0 of each word is output.
- RATIO==1: every edge is an LE, in_ready=1 permanently, and q equals the buffered word delayed by 2 cycles.
- Reset mid-word: the word in flight and the buffered word are both dropped, with no partial output afterward.
- in_data must be held stable only while in_valid & !in_ready. The block never drops an accepted word except on align truncation or reset.

Test Plan:
(All scenarios use DW=8, OW=2, MSB_FIRST=1, IDLE_WORD=8'h00 unless stated.)
1. Reset, then idle for 8 cycles -> q=00 throughout; q_first high every 4th cycle starting at cnt=0; q_idle=1; in_ready=1; underrun=0.
2. Stream 8'hA5, 8'h3C, 8'hFF back-to-back with in_valid held -> q = 10,10,01,01 | 00,11,11,00 | 11,11,11,11 with no gap slices; q_first on each first slice; q_idle=0 across all three words.
3. Single word 8'h81, then in_valid=0 -> q = 10,00,00,01, then idle; underrun=1 at the following LE and stays set; pulse underrun_clr -> underrun=0.
4. in_valid held with 4 words queued -> in_ready=1 only in cnt==3 cycles once the buffer is full; no word lost or duplicated; output order is preserved.
5. Word 8'hA5 in flight; pulse align when cnt==1 -> q shows 10,10, then slice 0 of the buffered word (or idle) on the next cycle with q_first=1; the truncated slices never appear.
6. DW=OW=4, MSB_FIRST=0, stream 4'h1, 4'h2, 4'h3 -> in_ready=1 every cycle; q = 1,2,3 on consecutive cycles 2 cycles after accept; q_first=1 every cycle.

Source files
------------

// File: rtl/ice40_oserdes_gearbox.sv
// Transmit gearbox: DW-bit words in over valid/ready, OW-bit slices out per clock.
// A one-entry buffer feeds the shift register at each word boundary; idle words fill the gaps.
module ice40_oserdes_gearbox #(
    parameter int             DW        = 8,
    parameter int             OW        = 2,
    parameter bit             MSB_FIRST = 1'b1,
    parameter logic [DW-1:0]  IDLE_WORD = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          align,
    output logic [OW-1:0] q,
    output logic          q_first,
    output logic          q_idle,
    output logic          underrun,
    input  logic          underrun_clr
);

    localparam int RATIO = DW / OW;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [DW-1:0] sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          buf_full_q, buf_full_d;
    logic          cur_idle_q, cur_idle_d;
    logic          prev_data_q, prev_data_d;
    logic          underrun_q, underrun_d;

    logic le;
    logic accept;

    // A load edge closes the current word, either naturally or forced by align.
    assign le       = (cnt_q == LAST) | align;
    assign in_ready = ~buf_full_q | le;
    assign accept   = in_valid & in_ready;

    always_comb begin
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        cur_idle_d  = cur_idle_q;
        prev_data_d = prev_data_q;
        underrun_d  = underrun_q & ~underrun_clr;

        if (le) begin
            cnt_d       = '0;
            prev_data_d = buf_full_q;
            if (buf_full_q) begin
                sr_d       = buf_q;
                cur_idle_d = 1'b0;
            end else begin
                sr_d       = IDLE_WORD;
                cur_idle_d = 1'b1;
                // Set takes priority over a simultaneous clear.
                if (prev_data_q)
                    underrun_d = 1'b1;
            end
            buf_full_d = accept;
            if (accept)
                buf_d = in_data;
        end else begin
            cnt_d = cnt_q + CW'(1);
            sr_d  = MSB_FIRST ? (sr_q << OW) : (sr_q >> OW);
            if (accept) begin
                buf_d      = in_data;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q        <= IDLE_WORD;
            cnt_q       <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            cur_idle_q  <= 1'b1;
            prev_data_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            cur_idle_q  <= cur_idle_d;
            prev_data_q <= prev_data_d;
            underrun_q  <= underrun_d;
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb
            assign q = sr_q[DW-1 -: OW];
        end else begin : g_lsb
            assign q = sr_q[OW-1:0];
        end
    endgenerate

    assign q_first  = (cnt_q == '0);
    assign q_idle   = cur_idle_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_ice40_oserdes_gearbox.sv
// Bench for the gearbox: an 8/2 MSB-first instance and a 4/4 LSB-first instance,
// both compared every cycle against a word-level model, plus literal slice sequences.
module tb_ice40_oserdes_gearbox;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0, align = 1'b0, underrun_clr = 1'b0;
    logic       in_ready, q_first, q_idle, underrun;
    logic [1:0] q;

    logic [3:0] in_data2 = '0;
    logic       in_valid2 = 1'b0, align2 = 1'b0, underrun_clr2 = 1'b0;
    logic       in_ready2, q_first2, q_idle2, underrun2;
    logic [3:0] q2;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    ice40_oserdes_gearbox #(.DW(8), .OW(2), .MSB_FIRST(1'b1), .IDLE_WORD(8'h00)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .align(align), .q(q), .q_first(q_first), .q_idle(q_idle),
        .underrun(underrun), .underrun_clr(underrun_clr));

    ice40_oserdes_gearbox #(.DW(4), .OW(4), .MSB_FIRST(1'b0), .IDLE_WORD(4'h0)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .align(align2), .q(q2), .q_first(q_first2), .q_idle(q_idle2),
        .underrun(underrun2), .underrun_clr(underrun_clr2));

    always #5 clk = ~clk;

    // Word-level model, 8-bit instance: current word, slice index, pending word.
    logic [7:0] m_cur;
    bit         m_cur_idle, m_pend_full, m_prev, m_unr;
    logic [7:0] m_pend;
    int         m_pos;
    // Model, 4-bit instance (one slice per word).
    logic [3:0] m2_cur, m2_pend;
    bit         m2_cur_idle, m2_pend_full, m2_prev, m2_unr;

    logic [1:0] nlog[$];
    logic [3:0] log2[$];
    int         log2_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, exp);
        end
    endtask

    function automatic logic [1:0] slice8(input logic [7:0] w, input int p);
        logic [7:0] s;
        s = w >> (6 - 2 * p);
        return s[1:0];
    endfunction

    task automatic model_reset();
        m_cur = 8'h00; m_cur_idle = 1; m_pos = 0; m_pend = '0; m_pend_full = 0; m_prev = 0; m_unr = 0;
        m2_cur = 4'h0; m2_cur_idle = 1; m2_pend = '0; m2_pend_full = 0; m2_prev = 0; m2_unr = 0;
    endtask

    // Called at a falling edge: drive, check, advance model, move to next falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit al, input bit clr,
                        input bit v2, input logic [3:0] d2, input bit al2, input bit clr2,
                        output bit acc);
        bit bnd, macc, set_u;
        in_valid = v; in_data = d; align = al; underrun_clr = clr;
        in_valid2 = v2; in_data2 = d2; align2 = al2; underrun_clr2 = clr2;
        #1;
        bnd = (m_pos == 3) || al;
        chk("q", 32'(q), 32'(slice8(m_cur, m_pos)));
        chk("q_first", 32'(q_first), 32'(m_pos == 0));
        chk("q_idle", 32'(q_idle), 32'(m_cur_idle));
        chk("underrun", 32'(underrun), 32'(m_unr));
        chk("in_ready", 32'(in_ready), 32'(!m_pend_full || bnd));
        chk("q2", 32'(q2), 32'(m2_cur));
        chk("q_first2", 32'(q_first2), 32'd1);
        chk("q_idle2", 32'(q_idle2), 32'(m2_cur_idle));
        chk("underrun2", 32'(underrun2), 32'(m2_unr));
        chk("in_ready2", 32'(in_ready2), 32'd1);
        if (!q_idle) nlog.push_back(q);
        if (!q_idle2) begin log2.push_back(q2); log2_cyc.push_back(cycle); end
        acc = v && in_ready;

        macc = v && (!m_pend_full || bnd);
        if (bnd) begin
            set_u = m_prev && !m_pend_full;
            m_unr = set_u ? 1'b1 : (clr ? 1'b0 : m_unr);
            m_prev = m_pend_full;
            m_cur = m_pend_full ? m_pend : 8'h00;
            m_cur_idle = !m_pend_full;
            m_pos = 0;
            m_pend_full = macc;
            if (macc) m_pend = d;
        end else begin
            m_unr = clr ? 1'b0 : m_unr;
            m_pos++;
            if (macc) begin m_pend = d; m_pend_full = 1; end
        end

        set_u = m2_prev && !m2_pend_full;
        m2_unr = set_u ? 1'b1 : (clr2 ? 1'b0 : m2_unr);
        m2_prev = m2_pend_full;
        m2_cur = m2_pend_full ? m2_pend : 4'h0;
        m2_cur_idle = !m2_pend_full;
        m2_pend_full = v2;
        if (v2) m2_pend = d2;

        cycle++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 4'h0, 0, 0, a);
    endtask

    // Asynchronous assertion mid-cycle; outputs must change before any clock edge.
    task automatic do_reset();
        in_valid = 0; align = 0; underrun_clr = 0;
        in_valid2 = 0; align2 = 0; underrun_clr2 = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_q_first", 32'(q_first), 32'd1);
        chk("rst_q_idle", 32'(q_idle), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_in_ready2", 32'(in_ready2), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send8(input logic [7:0] w);
        bit a;
        int n;
        a = 0; n = 0;
        while (!a && n < 20) begin step(1, w, 0, 0, 0, 4'h0, 0, 0, a); n++; end
        checks++;
        if (!a) begin failures++; $display("FAIL send_timeout actual=none required=accept of %0h", w); end
    endtask

    initial begin
        logic [7:0] words[3];
        logic [1:0] exp2[12];
        int         i, n, k0;
        bit         a, found;

        model_reset();
        @(negedge clk);
        do_reset();

        // Idle after reset: all-zero slices, q_first every 4th cycle, no underrun.
        nlog.delete();
        idle(8);
        chk("idle_no_data", 32'(nlog.size()), 32'd0);
        chk("idle_underrun", 32'(underrun), 32'd0);

        // Back-to-back stream with valid held.
        words = '{8'hA5, 8'h3C, 8'hFF};
        exp2  = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00,
                  2'b11, 2'b11, 2'b11, 2'b11};
        i = 0; n = 0;
        while (i < 3 && n < 40) begin
            step(1, words[i], 0, 0, 0, 4'h0, 0, 0, a);
            if (a) i++;
            n++;
        end
        chk("stream_accepted", 32'(i), 32'd3);
        idle(14);
        chk("stream_len", 32'(nlog.size()), 32'd12);
        for (int j = 0; j < 12 && j < nlog.size(); j++) chk("stream_slice", 32'(nlog[j]), 32'(exp2[j]));
        chk("stream_underrun", 32'(underrun), 32'd1);

        // Single word then dry: underrun sticks until cleared.
        step(0, 8'h00, 0, 1, 0, 4'h0, 0, 0, a);
        chk("clr_underrun", 32'(underrun), 32'd0);
        nlog.delete();
        send8(8'h81);
        idle(12);
        chk("single_len", 32'(nlog.size()), 32'd4);
        if (nlog.size() == 4) begin
            chk("single_s0", 32'(nlog[0]), 32'h2);
            chk("single_s1", 32'(nlog[1]), 32'h0);
            chk("single_s2", 32'(nlog[2]), 32'h0);
            chk("single_s3", 32'(nlog[3]), 32'h1);
        end
        chk("single_underrun", 32'(underrun), 32'd1);
        idle(5);
        chk("underrun_sticky", 32'(underrun), 32'd1);
        step(0, 8'h00, 0, 1, 0, 4'h0, 0, 0, a);
        chk("underrun_cleared", 32'(underrun), 32'd0);

        // Align at slice 1 truncates the word.
        nlog.delete();
        send8(8'hA5);
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (q_first && !q_idle) found = 1;
            else step(0, 8'h00, 0, 0, 0, 4'h0, 0, 0, a);
        end
        chk("align_word_seen", 32'(found), 32'd1);
        step(0, 8'h00, 0, 0, 0, 4'h0, 0, 0, a);
        step(0, 8'h00, 1, 0, 0, 4'h0, 0, 0, a);
        chk("align_q_first", 32'(q_first), 32'd1);
        chk("align_q_idle", 32'(q_idle), 32'd1);
        idle(8);
        chk("align_len", 32'(nlog.size()), 32'd2);
        if (nlog.size() == 2) begin
            chk("align_s0", 32'(nlog[0]), 32'h2);
            chk("align_s1", 32'(nlog[1]), 32'h2);
        end
        step(0, 8'h00, 0, 1, 0, 4'h0, 0, 0, a);

        // Ratio-1 instance: q follows the accepted word two cycles later.
        log2.delete(); log2_cyc.delete();
        k0 = cycle;
        step(0, 8'h00, 0, 0, 1, 4'h1, 0, 0, a);
        step(0, 8'h00, 0, 0, 1, 4'h2, 0, 0, a);
        step(0, 8'h00, 0, 0, 1, 4'h3, 0, 0, a);
        idle(4);
        chk("r1_len", 32'(log2.size()), 32'd3);
        for (int j = 0; j < 3 && j < log2.size(); j++) begin
            chk("r1_data", 32'(log2[j]), 32'(j + 1));
            chk("r1_latency", 32'(log2_cyc[j]), 32'(k0 + j + 2));
        end

        // Random traffic, including held-valid runs and a reset mid-stream.
        for (int c = 0; c < 3000; c++) begin
            bit v, al, cl, v2, al2, cl2;
            v   = (c % 600 < 200) ? 1'b1 : ($urandom_range(3) != 0);
            al  = ($urandom_range(19) == 0);
            cl  = ($urandom_range(9) == 0);
            v2  = ($urandom_range(2) != 0);
            al2 = ($urandom_range(7) == 0);
            cl2 = ($urandom_range(9) == 0);
            if (c == 1500) do_reset();
            step(v, 8'($urandom), al, cl, v2, 4'($urandom), al2, cl2, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
